piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in/serial-out transmitter; the sending end of the 8-bit serial link into SI_PO_ShiftReg. It accepts a parallel word on a load/ready handshake, drives it MSB-first on SO one bit per clk, then pulses latch for one cycle so the receiver transfers its shift register to PO. One SO/latch pair connects directly to the receiver's SI/latch; both blocks share clk and rst.

Parameters:
WIDTH, 8, word width in bits; also the number of shift cycles per word (must be >= 2).

Ports:
clk  input  1  rising-edge clock shared with receiver
rst  input  1  synchronous active-high reset
PI  input  WIDTH  parallel word; sampled only on an accepted load
load  input  1  request to send PI; accepted on a clk edge where load=1 and ready=1
ready  output  1  1 = transmitter can accept load this cycle
SO  output  1  serial data to receiver SI, registered, MSB-first
latch  output  1  one-cycle pulse after the last bit; drives receiver latch

Behaviour:
- Reset (rst=1 at a clk edge, has priority over everything): state=IDLE, shift reg=0, bit counter=0, SO=0, latch=0, ready=1. Reset mid-word aborts it: no further bits, no latch pulse.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, SHIFT, LATCH.
- IDLE: ready=1, SO=0, latch=0. Edge with load=1 -> capture PI into shift reg, counter=0, go SHIFT. load=0 -> stay.
- SHIFT: ready=0, latch=0, SO = shift reg MSB. Each edge: shift reg left by 1 (zero fill), counter+1. Edge where counter==WIDTH-1 -> go LATCH. Each bit is held on SO for exactly one cycle. Bit i (0 = first) is driven in cycle i after acceptance and equals PI[WIDTH-1-i].
- LATCH: latch=1 for exactly one cycle, SO=0, ready=0 (see optional feature). Next edge -> IDLE.
- Latency: load accepted at edge E0. First bit (PI[WIDTH-1]) is valid from E0 to E1. Last bit is valid from E(WIDTH-1) to E(WIDTH). latch is high from E(WIDTH) to E(WIDTH+1). ready returns high after E(WIDTH+1).
- Word period is WIDTH+2 cycles (8-bit: 10 cycles), counting the IDLE accept cycle.
- load while ready=0: ignored, not queued. PI changes after acceptance have no effect.
- Counter width: clog2(WIDTH) bits. It never wraps past WIDTH-1.
- Receiver contract: SI_PO_ShiftReg samples SO on the same edges and latches on the edge where latch=1. After that edge, its PO equals the transmitted PI.

Optional Feature:
Macro: PISO_B2B_EN
- Defined: back-to-back streaming. In LATCH, ready=1. An edge with load=1 in LATCH captures the new PI and goes directly to SHIFT, skipping IDLE. The first bit of the new word follows the latch cycle with no gap, giving a sustained word period of WIDTH+1 cycles. Without load, LATCH -> IDLE as in base behaviour.
- Undefined: ready=0 in LATCH, and every word passes through IDLE, exactly as in Behaviour.

Test Plan:
1. Reset, then hold load=0 for 5 cycles -> ready=1, SO=0, latch=0 throughout.
2. PI=8'hA5 with a 1-cycle load from IDLE -> SO=1,0,1,0,0,1,0,1 on cycles 0..7 after acceptance. latch=1 only in cycle 8. ready=0 from cycle 0 to 8, then 1. The connected SI_PO_ShiftReg shows PO=8'hA5 after the latch edge.
3. Accept PI=8'h3C, then pulse load with PI=8'hFF at cycle 4 -> second load ignored. Serial stream is exactly 0,0,1,1,1,1,0,0, and the receiver's PO=8'h3C.
4. Accept PI=8'hFF, then assert rst at cycle 3 -> next cycle SO=0, ready=1, no latch pulse. The receiver's PO is unchanged from its previous value.
5. Words 8'h81 then 8'h7E, load held high continuously -> without PISO_B2B_EN: latch pulses 10 cycles apart, streams 1,0,0,0,0,0,0,1 and 0,1,1,1,1,1,1,0. With PISO_B2B_EN: latch pulses 9 cycles apart, and 8'h7E's first bit immediately follows the first latch cycle.
6. WIDTH=4 instance, PI=4'b1001 -> SO=1,0,0,1, latch in cycle 4, ready high again from cycle 5.

Source files
------------

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load/ready handshake plus serial link signals for piso_shift_tx.
// master = word source driving PI/load; slave = the transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] PI;
    logic             load;
    logic             ready;
    logic             SO;
    logic             latch;

    modport master (
        output PI,
        output load,
        input  ready,
        input  SO,
        input  latch
    );

    modport slave (
        input  PI,
        input  load,
        output ready,
        output SO,
        output latch
    );
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter for the SI_PO_ShiftReg link.
// Sends a WIDTH-bit word MSB-first on SO, one bit per clk, then pulses latch once.
// Optional macro PISO_B2B_EN: ready stays high in the latch cycle so a new word
// can start with no idle gap (word period WIDTH+1 instead of WIDTH+2).
module piso_shift_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    piso_shift_tx_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PISO_B2B_EN
    localparam logic READY_IN_LATCH = 1'b1;
`else
    localparam logic READY_IN_LATCH = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             so_q,    so_d;
    logic             latch_q, latch_d;
    logic             ready_q, ready_d;

    // State, datapath and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            latch_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            latch_q <= latch_d;
            ready_q <= ready_d;
        end
    end

    // Next state and next output values; outputs are a function of the next state
    // so that each registered output is valid for the whole cycle after the edge.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        so_d    = 1'b0;
        latch_d = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready is always high here, so load alone is an accept
                if (bus.load) begin
                    state_d = ST_SHIFT;
                    sreg_d  = bus.PI;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
`ifdef PISO_B2B_EN
                if (bus.load) begin
                    state_d = ST_SHIFT;
                    sreg_d  = bus.PI;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            ST_IDLE:  ready_d = 1'b1;
            ST_SHIFT: so_d    = sreg_d[WIDTH-1];
            ST_LATCH: begin
                latch_d = 1'b1;
                ready_d = READY_IN_LATCH;
            end
            default:  ready_d = 1'b0;
        endcase
    end

    assign bus.SO    = so_q;
    assign bus.latch = latch_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed checks of piso_shift_tx (8-bit and 4-bit instances)
// with a behavioural SI_PO_ShiftReg receiver on the 8-bit link.
module tb_piso_shift_tx;

`ifdef PISO_B2B_EN
    localparam int  P2  = 9;     // cycle where the second streamed word starts
    localparam logic B2B = 1'b1;
`else
    localparam int  P2  = 10;
    localparam logic B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(8)) bus8 ();
    piso_shift_tx_if #(.WIDTH(4)) bus4 ();

    piso_shift_tx #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    piso_shift_tx #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // Receiver model: shifts SO in on every edge, transfers to po on latch.
    logic [7:0] rx_sr;
    logic [7:0] rx_po;
    always_ff @(posedge clk) begin
        rx_sr <= {rx_sr[6:0], bus8.SO};
        if (bus8.latch) rx_po <= rx_sr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one 8-bit word from IDLE and check every cycle through the ready return.
    // With pulse set, a stray load of 8'hFF is raised in cycle 4 and must be ignored.
    task automatic stream8(input string name, input logic [7:0] w, input bit pulse);
        bus8.PI   = w;
        bus8.load = 1'b1;
        step();
        bus8.load = 1'b0;
        bus8.PI   = ~w;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_so%0d", name, i),  32'(bus8.SO),    32'(w[7-i]));
            chk($sformatf("%s_rdy%0d", name, i), 32'(bus8.ready), 32'(0));
            chk($sformatf("%s_lat%0d", name, i), 32'(bus8.latch), 32'(0));
            if (pulse && i == 4) begin
                bus8.PI   = 8'hFF;
                bus8.load = 1'b1;
            end else begin
                bus8.load = 1'b0;
            end
            step();
        end
        chk({name, "_lat8"}, 32'(bus8.latch), 32'(1));
        chk({name, "_so8"},  32'(bus8.SO),    32'(0));
        chk({name, "_rdy8"}, 32'(bus8.ready), 32'(0));
        step();
        chk({name, "_rdy9"}, 32'(bus8.ready), 32'(1));
        chk({name, "_lat9"}, 32'(bus8.latch), 32'(0));
        chk({name, "_po"},   32'(rx_po),      32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic [3:0] w4;
        int         latches;
        int         l1;
        int         l2;
        logic       so_e;
        logic       lat_e;
        logic       rdy_e;

        rst       = 1'b1;
        bus8.PI   = '0;
        bus8.load = 1'b0;
        bus4.PI   = '0;
        bus4.load = 1'b0;
        step();
        step();
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("idle_rdy%0d", i),   32'(bus8.ready),  32'(1));
            chk($sformatf("idle_so%0d", i),    32'(bus8.SO),     32'(0));
            chk($sformatf("idle_lat%0d", i),   32'(bus8.latch),  32'(0));
            chk($sformatf("idle4_rdy%0d", i),  32'(bus4.ready),  32'(1));
            chk($sformatf("idle4_so%0d", i),   32'(bus4.SO),     32'(0));
            step();
        end

        // 2: single word
        stream8("a5", 8'hA5, 1'b0);
        step();

        // 3: load during shifting is ignored
        stream8("3c", 8'h3C, 1'b1);
        step();

        // 4: reset mid-word aborts without latch
        bus8.PI   = 8'hFF;
        bus8.load = 1'b1;
        step();
        bus8.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_so%0d", i), 32'(bus8.SO), 32'(1));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_so",  32'(bus8.SO),    32'(0));
        chk("rst_rdy", 32'(bus8.ready), 32'(1));
        chk("rst_lat", 32'(bus8.latch), 32'(0));
        latches = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.latch) latches++;
            step();
        end
        chk("rst_nolatch", 32'(latches), 32'(0));
        chk("rst_po",      32'(rx_po),   32'(8'h3C));

        // 5: two words with load held high
        w1 = 8'h81;
        w2 = 8'h7E;
        bus8.PI   = w1;
        bus8.load = 1'b1;
        step();
        bus8.PI = w2;
        l1 = -1;
        l2 = -1;
        for (int t = 0; t <= P2 + 9; t++) begin
            if (t < 8)                      so_e = w1[7-t];
            else if (t >= P2 && t < P2 + 8) so_e = w2[7-(t-P2)];
            else                            so_e = 1'b0;
            lat_e = (t == 8) || (t == P2 + 8);
            if (lat_e)                              rdy_e = B2B;
            else if (t >= P2 + 9)                   rdy_e = 1'b1;
            else if (t == 9 && !B2B)                rdy_e = 1'b1;
            else                                    rdy_e = 1'b0;
            chk($sformatf("b2b_so%0d", t),  32'(bus8.SO),    32'(so_e));
            chk($sformatf("b2b_lat%0d", t), 32'(bus8.latch), 32'(lat_e));
            chk($sformatf("b2b_rdy%0d", t), 32'(bus8.ready), 32'(rdy_e));
            if (bus8.latch) begin
                if (l1 < 0) l1 = t;
                else        l2 = t;
            end
            if (t == 9) chk("b2b_po1", 32'(rx_po), 32'(w1));
            if (t == P2) bus8.load = 1'b0;
            step();
        end
        chk("b2b_gap", 32'(l2 - l1), 32'(P2));
        chk("b2b_po2", 32'(rx_po),   32'(w2));

        // 6: 4-bit instance
        w4 = 4'b1001;
        bus4.PI   = w4;
        bus4.load = 1'b1;
        step();
        bus4.load = 1'b0;
        bus4.PI   = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w4_so%0d", i),  32'(bus4.SO),    32'(w4[3-i]));
            chk($sformatf("w4_lat%0d", i), 32'(bus4.latch), 32'(0));
            chk($sformatf("w4_rdy%0d", i), 32'(bus4.ready), 32'(0));
            step();
        end
        chk("w4_lat4", 32'(bus4.latch), 32'(1));
        chk("w4_rdy4", 32'(bus4.ready), 32'(0));
        step();
        chk("w4_rdy5", 32'(bus4.ready), 32'(1));
        chk("w4_lat5", 32'(bus4.latch), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
